// File: rtl/cpu_pkg.sv
// Shared core types: default datapath widths and the write-back entry bundle.
// The bundle is reused by the EX/MEM and MEM/WB stages.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_RD_W   = 4;

    typedef struct packed {
        logic                  reg_write;
        logic                  reg_store;
        logic [CPU_DATA_W-1:0] alu_result;
        logic [CPU_DATA_W-1:0] store_mem;
        logic [CPU_RD_W-1:0]   rd;
    } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB handshake bundle; slave = stage, master = surrounding pipeline.
// Forwarding taps exist only when WB_FWD_EN is defined.
interface mem_wb_stage_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int RD_W   = CPU_RD_W
);
    logic              IValid;
    logic              OReady;
    logic              IRegWrite;
    logic              IRegStore;
    logic [DATA_W-1:0] IALUResult;
    logic [DATA_W-1:0] IStoreMem;
    logic [RD_W-1:0]   IRd;
    logic              IFlush;
    logic              OValid;
    logic              IReady;
    logic              ORegWrite;
    logic              ORegStore;
    logic [DATA_W-1:0] OALUResult;
    logic [DATA_W-1:0] OStoreMem;
    logic [RD_W-1:0]   ORd;
    logic [1:0]        OCount;
`ifdef WB_FWD_EN
    logic              OFwdValid;
    logic [RD_W-1:0]   OFwdRd;
    logic [DATA_W-1:0] OFwdData;

    modport slave (
        input  IValid, IRegWrite, IRegStore, IALUResult,
        input  IStoreMem, IRd, IFlush, IReady,
        output OReady, OValid, ORegWrite, ORegStore,
        output OALUResult, OStoreMem, ORd, OCount,
        output OFwdValid, OFwdRd, OFwdData
    );

    modport master (
        output IValid, IRegWrite, IRegStore, IALUResult,
        output IStoreMem, IRd, IFlush, IReady,
        input  OReady, OValid, ORegWrite, ORegStore,
        input  OALUResult, OStoreMem, ORd, OCount,
        input  OFwdValid, OFwdRd, OFwdData
    );
`else
    modport slave (
        input  IValid, IRegWrite, IRegStore, IALUResult,
        input  IStoreMem, IRd, IFlush, IReady,
        output OReady, OValid, ORegWrite, ORegStore,
        output OALUResult, OStoreMem, ORd, OCount
    );

    modport master (
        output IValid, IRegWrite, IRegStore, IALUResult,
        output IStoreMem, IRd, IFlush, IReady,
        input  OReady, OValid, ORegWrite, ORegStore,
        input  OALUResult, OStoreMem, ORd, OCount
    );
`endif
endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready is registered, so out_ready never reaches the input side.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         consume;

    assign accept  = in_valid && !skid_valid_q;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_d       = '0;
            skid_d       = '0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // Skid is full, so no accept can coincide here.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: skid-buffered write-back bundle with flush.
// Define WB_FWD_EN to expose combinational forwarding taps from the head.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int RD_W   = CPU_RD_W
) (
    input logic           CLK,
    input logic           Reset,
    mem_wb_stage_if.slave bus
);
    typedef struct packed {
        logic              reg_write;
        logic              reg_store;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_mem;
        logic [RD_W-1:0]   rd;
    } slot_t;

    localparam int W = $bits(slot_t);

    slot_t in_s;
    slot_t out_s;
    logic  out_valid;

    always_comb begin
        in_s.reg_write  = bus.IRegWrite;
        in_s.reg_store  = bus.IRegStore;
        in_s.alu_result = bus.IALUResult;
        in_s.store_mem  = bus.IStoreMem;
        in_s.rd         = bus.IRd;
    end

    skid_buffer #(.W(W)) u_skid (
        .clk       (CLK),
        .rst_n     (Reset),
        .flush     (bus.IFlush),
        .in_valid  (bus.IValid),
        .in_ready  (bus.OReady),
        .in_data   (in_s),
        .out_valid (out_valid),
        .out_ready (bus.IReady),
        .out_data  (out_s),
        .count     (bus.OCount)
    );

    assign bus.OValid     = out_valid;
    assign bus.ORegWrite  = out_s.reg_write;
    assign bus.ORegStore  = out_s.reg_store;
    assign bus.OALUResult = out_s.alu_result;
    assign bus.OStoreMem  = out_s.store_mem;
    assign bus.ORd        = out_s.rd;

`ifdef WB_FWD_EN
    assign bus.OFwdValid = out_valid && out_s.reg_write;
    assign bus.OFwdRd    = out_s.rd;
    assign bus.OFwdData  = out_s.reg_store ? out_s.store_mem
                                           : out_s.alu_result;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: default 16/4 instance plus a 32/5 instance.
// Define WB_FWD_EN to also check the forwarding taps.
module tb_mem_wb_stage;

    logic CLK;
    logic Reset;
    int   n_tests;
    int   n_fail;

    mem_wb_stage_if #(.DATA_W(16), .RD_W(4)) a();
    mem_wb_stage_if #(.DATA_W(32), .RD_W(5)) b();

    mem_wb_stage #(.DATA_W(16), .RD_W(4)) dut_a (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (a)
    );

    mem_wb_stage #(.DATA_W(32), .RD_W(5)) dut_b (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic rw, input logic rs,
                           input logic [15:0] alu, input logic [15:0] mem,
                           input logic [3:0] rd);
        a.IValid     = v;
        a.IRegWrite  = rw;
        a.IRegStore  = rs;
        a.IALUResult = alu;
        a.IStoreMem  = mem;
        a.IRd        = rd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset   = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        a.IFlush = 1'b0;
        a.IReady = 1'b0;
        b.IValid = 1'b0;
        b.IRegWrite = 1'b0;
        b.IRegStore = 1'b0;
        b.IALUResult = 32'h0;
        b.IStoreMem = 32'h0;
        b.IRd = 5'h0;
        b.IFlush = 1'b0;
        b.IReady = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ovalid", 64'(a.OValid), 64'h0);
        chk("rst_oready", 64'(a.OReady), 64'h1);
        chk("rst_ocount", 64'(a.OCount), 64'h0);
        chk("rst_ord", 64'(a.ORd), 64'h0);
        chk("rst_oalu", 64'(a.OALUResult), 64'h0);
        Reset = 1'b1;
        step();
        chk("post_rst_oready", 64'(a.OReady), 64'h1);
        chk("post_rst_ovalid", 64'(a.OValid), 64'h0);

        // Stream 4 entries with IReady held high
        a.IReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 1'b1, 1'b0, 16'(i * 16'h0011), 16'h0, 4'(i));
            step();
            chk("stream_ovalid", 64'(a.OValid), 64'h1);
            chk("stream_ord", 64'(a.ORd), 64'(i));
            chk("stream_alu", 64'(a.OALUResult), 64'(i * 17));
            chk("stream_count", 64'(a.OCount), 64'h1);
        end
        a.IValid = 1'b0;
        step();
        chk("drain_ovalid", 64'(a.OValid), 64'h0);
        chk("drain_count", 64'(a.OCount), 64'h0);
        chk("drain_ord_hold", 64'(a.ORd), 64'h4);

        // Back-pressure: A then B with IReady low
        a.IReady = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0, 16'h0055, 16'h0, 4'd5);
        step();
        chk("bp_a_count", 64'(a.OCount), 64'h1);
        drive_a(1'b1, 1'b1, 1'b0, 16'h0066, 16'h0, 4'd6);
        step();
        chk("bp_full_count", 64'(a.OCount), 64'h2);
        chk("bp_full_oready", 64'(a.OReady), 64'h0);
        chk("bp_full_ord", 64'(a.ORd), 64'h5);
        a.IValid = 1'b0;
        step();
        chk("bp_hold_ord", 64'(a.ORd), 64'h5);
        chk("bp_hold_count", 64'(a.OCount), 64'h2);
        a.IReady = 1'b1;
        step();
        chk("bp_pop1_ord", 64'(a.ORd), 64'h6);
        chk("bp_pop1_alu", 64'(a.OALUResult), 64'h66);
        chk("bp_pop1_oready", 64'(a.OReady), 64'h1);
        chk("bp_pop1_count", 64'(a.OCount), 64'h1);
        step();
        chk("bp_pop2_ovalid", 64'(a.OValid), 64'h0);
        chk("bp_pop2_count", 64'(a.OCount), 64'h0);

        // Flush with 2 entries held and IValid high
        a.IReady = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0, 16'h0088, 16'h0, 4'd8);
        step();
        drive_a(1'b1, 1'b1, 1'b0, 16'h0099, 16'h0, 4'd9);
        step();
        chk("fl_pre_count", 64'(a.OCount), 64'h2);
        drive_a(1'b1, 1'b1, 1'b0, 16'h00AA, 16'h0, 4'd10);
        a.IFlush = 1'b1;
        step();
        chk("fl_ovalid", 64'(a.OValid), 64'h0);
        chk("fl_count", 64'(a.OCount), 64'h0);
        chk("fl_oregwrite", 64'(a.ORegWrite), 64'h0);
        chk("fl_oready", 64'(a.OReady), 64'h1);
        a.IFlush = 1'b0;
        a.IValid = 1'b0;
        a.IReady = 1'b1;
        step();
        chk("fl_no_ghost", 64'(a.OValid), 64'h0);

        // Flush with one entry held while OReady is high
        a.IReady = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0, 16'h00BB, 16'h0, 4'd11);
        step();
        chk("fl1_pre_count", 64'(a.OCount), 64'h1);
        drive_a(1'b1, 1'b1, 1'b0, 16'h00CC, 16'h0, 4'd12);
        a.IFlush = 1'b1;
        step();
        chk("fl1_count", 64'(a.OCount), 64'h0);
        chk("fl1_ovalid", 64'(a.OValid), 64'h0);
        a.IFlush = 1'b0;
        a.IValid = 1'b0;
        step();
        chk("fl1_no_ghost", 64'(a.OValid), 64'h0);

        // Asynchronous reset mid-cycle with a valid head
        drive_a(1'b1, 1'b1, 1'b1, 16'h00AB, 16'h00CD, 4'd13);
        step();
        chk("ar_pre_ovalid", 64'(a.OValid), 64'h1);
        chk("ar_pre_mem", 64'(a.OStoreMem), 64'hCD);
        a.IValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("ar_ovalid", 64'(a.OValid), 64'h0);
        chk("ar_ord", 64'(a.ORd), 64'h0);
        chk("ar_alu", 64'(a.OALUResult), 64'h0);
        chk("ar_mem", 64'(a.OStoreMem), 64'h0);
        chk("ar_regwrite", 64'(a.ORegWrite), 64'h0);
        chk("ar_regstore", 64'(a.ORegStore), 64'h0);
        chk("ar_count", 64'(a.OCount), 64'h0);
        chk("ar_oready", 64'(a.OReady), 64'h1);
        step();
        Reset = 1'b1;
        step();

        // Load-data select entry, then same entry with IRegWrite low
        a.IReady = 1'b0;
        drive_a(1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'd7);
        step();
        chk("ld_mem", 64'(a.OStoreMem), 64'hBEEF);
        chk("ld_alu", 64'(a.OALUResult), 64'h1234);
        chk("ld_regstore", 64'(a.ORegStore), 64'h1);
`ifdef WB_FWD_EN
        chk("fwd_data", 64'(a.OFwdData), 64'hBEEF);
        chk("fwd_rd", 64'(a.OFwdRd), 64'h7);
        chk("fwd_valid", 64'(a.OFwdValid), 64'h1);
`endif
        a.IReady = 1'b1;
        drive_a(1'b1, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 4'd7);
        step();
        chk("nowr_ovalid", 64'(a.OValid), 64'h1);
        chk("nowr_regwrite", 64'(a.ORegWrite), 64'h0);
`ifdef WB_FWD_EN
        chk("fwd_nowr_valid", 64'(a.OFwdValid), 64'h0);
`endif
        drive_a(1'b1, 1'b1, 1'b0, 16'h1234, 16'hBEEF, 4'd3);
        step();
        chk("alu_sel_ord", 64'(a.ORd), 64'h3);
        chk("alu_sel_regstore", 64'(a.ORegStore), 64'h0);
`ifdef WB_FWD_EN
        chk("fwd_alu_data", 64'(a.OFwdData), 64'h1234);
`endif
        a.IValid = 1'b0;

        // Wide instance passes values unchanged
        b.IReady = 1'b1;
        b.IValid = 1'b1;
        b.IRegWrite = 1'b1;
        b.IRegStore = 1'b0;
        b.IALUResult = 32'hDEADBEEF;
        b.IStoreMem = 32'hCAFEF00D;
        b.IRd = 5'd31;
        step();
        chk("w_ovalid", 64'(b.OValid), 64'h1);
        chk("w_alu", 64'(b.OALUResult), 64'hDEADBEEF);
        chk("w_mem", 64'(b.OStoreMem), 64'hCAFEF00D);
        chk("w_rd", 64'(b.ORd), 64'd31);
        b.IValid = 1'b0;
        step();
        chk("w_drain_ovalid", 64'(b.OValid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
